// File: rtl/ov7670_pkg.sv
// Shared widths, the freeze-state encoding and the frame buffer address range helper
// for the camera frame buffer write path.
package ov7670_pkg;

    localparam int c_img_pxls    = 76800;
    localparam int c_nb_img_pxls = 17;
    localparam int c_nb_buf      = 12;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FRZ_PEND   = 2'd1,
        FROZEN     = 2'd2,
        UNFRZ_PEND = 2'd3
    } freeze_st_t;

    function automatic logic addr_in_range(input logic [c_nb_img_pxls-1:0] addr);
        return (addr < 17'(c_img_pxls));
    endfunction

endpackage

// File: rtl/fb_freeze_fsm.sv
// Frame-aligned freeze control: freeze and unfreeze requests take effect only on a
// capture frame start, so the buffer always holds a complete image.
module fb_freeze_fsm
    import ov7670_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic freeze_req,
    input  logic cap_frame_start,
    output logic cap_allow,
    output logic frozen,
    output logic in_run
);

    freeze_st_t st_q;
    freeze_st_t st_d;
    logic       frozen_q;

    // Next state; a request level that changes before the frame start cancels the pending move.
    always_comb begin
        st_d = st_q;
        case (st_q)
            RUN: begin
                if (freeze_req) st_d = FRZ_PEND;
                else            st_d = RUN;
            end
            FRZ_PEND: begin
                if (!freeze_req)          st_d = RUN;
                else if (cap_frame_start) st_d = FROZEN;
                else                      st_d = FRZ_PEND;
            end
            FROZEN: begin
                if (!freeze_req) st_d = UNFRZ_PEND;
                else             st_d = FROZEN;
            end
            UNFRZ_PEND: begin
                if (freeze_req)           st_d = FROZEN;
                else if (cap_frame_start) st_d = RUN;
                else                      st_d = UNFRZ_PEND;
            end
            default: st_d = RUN;
        endcase
    end

    // State register with the frozen flag registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= RUN;
            frozen_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            frozen_q <= (st_d == FROZEN) || (st_d == UNFRZ_PEND);
        end
    end

    // The capture write on the freezing frame-start edge is already part of the next frame.
    assign cap_allow = (st_q == RUN) || ((st_q == FRZ_PEND) && (st_d != FROZEN));
    assign frozen    = frozen_q;
    assign in_run    = (st_q == RUN);

endmodule

// File: rtl/fb_wr_arbiter.sv
// Shares the cam_fb write port between capture (fixed priority) and processing
// (valid/ready). Define FB_ARB_STATS_EN to add the stall_cnt/frame_cnt outputs.
module fb_wr_arbiter
    import ov7670_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_we,
    input  logic [c_nb_img_pxls-1:0] cap_addr,
    input  logic [c_nb_buf-1:0]      cap_data,
    input  logic                     cap_frame_start,
    input  logic                     freeze_req,
    input  logic                     proc_valid,
    input  logic [c_nb_img_pxls-1:0] proc_addr,
    input  logic [c_nb_buf-1:0]      proc_data,
    output logic                     proc_ready,
    output logic                     fb_we,
    output logic [c_nb_img_pxls-1:0] fb_addr,
    output logic [c_nb_buf-1:0]      fb_din,
    output logic                     frozen,
    output logic                     addr_err
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              frame_cnt
`endif
);

    logic                     cap_allow_s;
    logic                     in_run_s;
    logic                     cap_win_s;
    logic                     proc_xfer_s;
    logic                     accept_s;
    logic                     in_range_s;
    logic [c_nb_img_pxls-1:0] sel_addr_s;
    logic [c_nb_buf-1:0]      sel_data_s;

    logic                     fb_we_q;
    logic [c_nb_img_pxls-1:0] fb_addr_q;
    logic [c_nb_buf-1:0]      fb_din_q;
    logic                     addr_err_q;

    fb_freeze_fsm u_freeze (
        .clk             (clk),
        .rst             (rst),
        .freeze_req      (freeze_req),
        .cap_frame_start (cap_frame_start),
        .cap_allow       (cap_allow_s),
        .frozen          (frozen),
        .in_run          (in_run_s)
    );

    // Grant and source select; a blocked capture pulse is simply dropped.
    always_comb begin
        cap_win_s   = cap_we & cap_allow_s;
        proc_xfer_s = proc_valid & ~cap_win_s;
        accept_s    = cap_win_s | proc_xfer_s;
        if (cap_win_s) begin
            sel_addr_s = cap_addr;
            sel_data_s = cap_data;
        end else begin
            sel_addr_s = proc_addr;
            sel_data_s = proc_data;
        end
        in_range_s = addr_in_range(sel_addr_s);
    end

    assign proc_ready = ~cap_win_s;

    // Registered write port; address/data hold while no write is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_din_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            fb_we_q    <= accept_s & in_range_s;
            addr_err_q <= accept_s & ~in_range_s;
            if (accept_s) begin
                fb_addr_q <= sel_addr_s;
                fb_din_q  <= sel_data_s;
            end else begin
                fb_addr_q <= fb_addr_q;
                fb_din_q  <= fb_din_q;
            end
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_din   = fb_din_q;
    assign addr_err = addr_err_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] frame_cnt_q;

    // Saturating stall and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            frame_cnt_q <= 16'h0000;
        end else begin
            if (proc_valid && cap_win_s && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            else
                stall_cnt_q <= stall_cnt_q;
            if (cap_frame_start && in_run_s && (frame_cnt_q != 16'hFFFF))
                frame_cnt_q <= frame_cnt_q + 16'h0001;
            else
                frame_cnt_q <= frame_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Self-checking bench for fb_wr_arbiter: directed scenarios followed by random traffic,
// checked against a frame-level behavioural model.
module tb_fb_wr_arbiter;

    localparam int IMG = 76800;

    logic        clk;
    logic        rst;
    logic        cap_we;
    logic [16:0] cap_addr;
    logic [11:0] cap_data;
    logic        cap_frame_start;
    logic        freeze_req;
    logic        proc_valid;
    logic [16:0] proc_addr;
    logic [11:0] proc_data;
    logic        proc_ready;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [11:0] fb_din;
    logic        frozen;
    logic        addr_err;
`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] frame_cnt;
`endif

    fb_wr_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .cap_we          (cap_we),
        .cap_addr        (cap_addr),
        .cap_data        (cap_data),
        .cap_frame_start (cap_frame_start),
        .freeze_req      (freeze_req),
        .proc_valid      (proc_valid),
        .proc_addr       (proc_addr),
        .proc_data       (proc_data),
        .proc_ready      (proc_ready),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_din          (fb_din),
        .frozen          (frozen),
        .addr_err        (addr_err)
`ifdef FB_ARB_STATS_EN
        ,
        .stall_cnt       (stall_cnt),
        .frame_cnt       (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: image frozen flag, last sampled request level, expected port registers.
    bit          m_frz;
    bit          m_prev_req;
    logic        m_we;
    logic        m_err;
    logic [16:0] m_addr;
    logic [11:0] m_din;
    int          m_stall;
    int          m_frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frz = 1'b0; m_prev_req = 1'b0;
        m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_din = '0;
        m_stall = 0; m_frames = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".fb_we"},    {31'd0, fb_we},    {31'd0, m_we});
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
        chk({tag, ".fb_addr"},  {15'd0, fb_addr},  {15'd0, m_addr});
        chk({tag, ".fb_din"},   {20'd0, fb_din},   {20'd0, m_din});
        chk({tag, ".frozen"},   {31'd0, frozen},   {31'd0, m_frz});
`ifdef FB_ARB_STATS_EN
        chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, m_stall);
        chk({tag, ".frame_cnt"}, {16'd0, frame_cnt}, m_frames);
`endif
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input string tag, input bit cw, input int ca, input bit [11:0] cd,
                       input bit fs, input bit fr, input bit pv, input int pa,
                       input bit [11:0] pd, output bit accepted);
        bit nxt_frz, allow, cwin, rdy, xfer;
        int a;
        bit [11:0] d;
        cap_we = cw; cap_addr = ca[16:0]; cap_data = cd;
        cap_frame_start = fs; freeze_req = fr;
        proc_valid = pv; proc_addr = pa[16:0]; proc_data = pd;
        #1;
        // A frame start commits the request level only if it has been stable for a cycle.
        nxt_frz = (fs && (m_prev_req == fr)) ? fr : m_frz;
        allow   = !m_frz && !nxt_frz;
        cwin    = cw && allow;
        rdy     = !cwin;
        xfer    = pv && rdy;
        chk({tag, ".proc_ready"}, {31'd0, proc_ready}, {31'd0, rdy});
        if (pv && !rdy && m_stall < 65535) m_stall++;
        if (fs && !m_frz && !m_prev_req && m_frames < 65535) m_frames++;
        a = cwin ? ca : pa;
        d = cwin ? cd : pd;
        if (cwin || xfer) begin
            m_we = (a < IMG); m_err = (a >= IMG);
            m_addr = a[16:0]; m_din = d;
        end else begin
            m_we = 1'b0; m_err = 1'b0;
        end
        m_frz = nxt_frz;
        m_prev_req = fr;
        accepted = xfer;
        @(negedge clk);
        chk_outputs(tag);
    endtask

    task automatic idle(input string tag, input bit fr, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 0, 12'h0, 1'b0, fr, 1'b0, 0, 12'h0, acc);
    endtask

    initial begin
        bit acc;
        bit p_pend;
        int p_addr, rnd_addr;
        bit [11:0] p_data;
        bit fr_lvl;

        rst = 1'b1; cap_we = 1'b0; cap_addr = '0; cap_data = '0; cap_frame_start = 1'b0;
        freeze_req = 1'b0; proc_valid = 1'b0; proc_addr = '0; proc_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_outputs("reset");
        rst = 1'b0;

        // 1: capture every 4 clocks, addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            cyc("t1_cap", 1'b1, i, 12'(12'h100 + i), 1'b0, 1'b0, 1'b0, 0, 12'h0, acc);
            idle("t1_idle", 1'b0, 3);
        end

        // 2: collision, capture first then processing.
        cyc("t2_both", 1'b1, 10, 12'hAAA, 1'b0, 1'b0, 1'b1, 20, 12'h555, acc);
        cyc("t2_proc", 1'b0, 0, 12'h0, 1'b0, 1'b0, 1'b1, 20, 12'h555, acc);
        idle("t2_idle", 1'b0, 1);

        // 3: freeze requested mid-frame, takes effect at the frame start.
        for (int i = 0; i < 3; i++)
            cyc("t3_pend", 1'b1, 100 + i, 12'h3C0, 1'b0, 1'b1, 1'b0, 0, 12'h0, acc);
        cyc("t3_edge", 1'b1, 200, 12'h3C1, 1'b1, 1'b1, 1'b0, 0, 12'h0, acc);
        for (int i = 0; i < 3; i++)
            cyc("t3_frz", 1'b1, 300 + i, 12'h3C2, 1'b0, 1'b1, 1'b1, 400 + i, 12'h7E0, acc);

        // 4: unfreeze waits for the next frame start.
        for (int i = 0; i < 3; i++)
            cyc("t4_pend", 1'b1, 500 + i, 12'h0F0, 1'b0, 1'b0, 1'b0, 0, 12'h0, acc);
        cyc("t4_edge", 1'b1, 600, 12'h0F1, 1'b1, 1'b0, 1'b0, 0, 12'h0, acc);
        cyc("t4_resume", 1'b1, 601, 12'h0F2, 1'b0, 1'b0, 1'b0, 0, 12'h0, acc);

        // 5: range boundary.
        cyc("t5_oob", 1'b0, 0, 12'h0, 1'b0, 1'b0, 1'b1, IMG, 12'hBAD, acc);
        cyc("t5_last", 1'b0, 0, 12'h0, 1'b0, 1'b0, 1'b1, IMG - 1, 12'hABC, acc);
        idle("t5_idle", 1'b0, 1);

        // 6: async reset with a write in flight.
        cyc("t6_wr", 1'b1, 7, 12'h777, 1'b0, 1'b0, 1'b0, 0, 12'h0, acc);
        cap_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc("t6_run", 1'b1, 8, 12'h888, 1'b0, 1'b0, 1'b0, 0, 12'h0, acc);

        // Random traffic; processing holds its request until accepted.
        p_pend = 1'b0; p_addr = 0; p_data = '0; fr_lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!p_pend && ($urandom % 3 == 0)) begin
                p_pend = 1'b1;
                p_addr = ($urandom % 8 == 0) ? $urandom_range(IMG - 4, IMG + 4)
                                             : $urandom_range(0, IMG - 1);
                p_data = 12'($urandom);
            end
            if ($urandom % 25 == 0) fr_lvl = ~fr_lvl;
            rnd_addr = ($urandom % 10 == 0) ? $urandom_range(IMG - 2, IMG + 2)
                                             : $urandom_range(0, IMG - 1);
            cyc("rnd", ($urandom % 3 == 0), rnd_addr, 12'($urandom),
                ($urandom % 15 == 0), fr_lvl, p_pend, p_addr, p_data, acc);
            if (acc) p_pend = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
